// File: rtl/b06_peripheral.sv
// Responder for the b06 interrupt handler: tracks pending enable/interrupt requests,
// drives EQL/CONT_EQL and grant pulses. Define B06_PERIPH_CHECK_EN to build the protocol checker.
module b06_peripheral #(
    parameter int CNT_W       = 4,
    parameter int LIMIT       = 10,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [1:0] CC_MUX,
    input  logic [1:0] USCITE,
    input  logic       ENABLE_COUNT,
    input  logic       ACKOUT,
    output logic       EQL,
    output logic       CONT_EQL,
    input  logic       en_req,
    input  logic       intr_req,
    output logic       en_grant,
    output logic       intr_grant,
    output logic       busy,
    output logic       proto_err
);

    localparam logic [3:0]       HOLD_M1  = 4'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

    logic             pend_en_reg, pend_en_next;
    logic             pend_intr_reg, pend_intr_next;
    logic [3:0]       hold_reg, hold_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       cc_prev_reg, usc_prev_reg;
    logic             eql_reg, eql_next;
    logic             cont_eql_reg;
    logic             en_grant_reg, intr_grant_reg;
    logic             busy_reg, busy_next;

    logic en_det, intr_det, ack_entry, wrap;

    always_comb begin
        en_det    = (cc_prev_reg == 2'b11) && (CC_MUX == 2'b01);
        intr_det  = (USCITE == 2'b11) && (usc_prev_reg != 2'b11);
        ack_entry = (CC_MUX == 2'b11) && (cc_prev_reg != 2'b11);

        // A new request in the grant cycle wins over the clear.
        pend_en_next   = en_req   | (pend_en_reg   & ~en_det);
        pend_intr_next = intr_req | (pend_intr_reg & ~intr_det);

        hold_next = '0;
        if (ack_entry)
            hold_next = HOLD_M1;
        else if ((CC_MUX == 2'b11) && (hold_reg != 4'd0))
            hold_next = hold_reg - 4'd1;

        // EQL follows the post-update pend flags so a grant drops it on the same edge.
        eql_next = 1'b0;
        case (CC_MUX)
            2'b01:   eql_next = pend_en_next;
            2'b10:   eql_next = pend_intr_next;
            2'b11:   eql_next = ack_entry | (hold_reg != 4'd0);
            default: eql_next = 1'b0;
        endcase

        wrap     = ENABLE_COUNT && (cnt_reg == LIMIT_M1);
        cnt_next = cnt_reg;
        if (wrap)
            cnt_next = '0;
        else if (ENABLE_COUNT)
            cnt_next = cnt_reg + 1'b1;

        busy_next = pend_en_next | pend_intr_next | (hold_next != 4'd0);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pend_en_reg    <= 1'b0;
            pend_intr_reg  <= 1'b0;
            hold_reg       <= '0;
            cnt_reg        <= '0;
            cc_prev_reg    <= 2'b00;
            usc_prev_reg   <= 2'b00;
            eql_reg        <= 1'b0;
            cont_eql_reg   <= 1'b0;
            en_grant_reg   <= 1'b0;
            intr_grant_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            pend_en_reg    <= pend_en_next;
            pend_intr_reg  <= pend_intr_next;
            hold_reg       <= hold_next;
            cnt_reg        <= cnt_next;
            cc_prev_reg    <= CC_MUX;
            usc_prev_reg   <= USCITE;
            eql_reg        <= eql_next;
            cont_eql_reg   <= wrap;
            en_grant_reg   <= en_det;
            intr_grant_reg <= intr_det;
            busy_reg       <= busy_next;
        end
    end

`ifdef B06_PERIPH_CHECK_EN
    logic proto_err_reg;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            proto_err_reg <= 1'b0;
        else if ((ENABLE_COUNT != ACKOUT) || (USCITE == 2'b10))
            proto_err_reg <= 1'b1;
    end

    assign proto_err = proto_err_reg;
`else
    logic unused_ackout;
    assign unused_ackout = ACKOUT;
    assign proto_err     = 1'b0;
`endif

    assign EQL        = eql_reg;
    assign CONT_EQL   = cont_eql_reg;
    assign en_grant   = en_grant_reg;
    assign intr_grant = intr_grant_reg;
    assign busy       = busy_reg;

endmodule
